// File: rtl/rf_psum_bank_if.sv
// Drain stream from a PE's partial-sum bank to the global buffer.
// The bank drives the word and its tags; the buffer side answers with ready.
interface rf_psum_bank_if #(
    parameter int OUT_BITWIDTH       = 16,
    parameter int PSUM_ADDR_BITWIDTH = 2
);
    logic                          drain_valid;
    logic                          drain_ready;
    logic [OUT_BITWIDTH-1:0]       drain_data;
    logic [PSUM_ADDR_BITWIDTH-1:0] drain_addr;
    logic                          drain_last;

    modport master (
        output drain_valid,
        output drain_data,
        output drain_addr,
        output drain_last,
        input  drain_ready
    );

    modport slave (
        input  drain_valid,
        input  drain_data,
        input  drain_addr,
        input  drain_last,
        output drain_ready
    );
endinterface

// File: rtl/rf_psum_bank.sv
// Partial-sum register file behind a MAC: stores tagged results, feeds them back
// on sum_out, and streams the whole bank out over a valid/ready drain port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepts MAC writes and clear; drain_start launches a drain
// ST_DRAIN | presents mem[idx] on the drain port; MAC writes are dropped
module rf_psum_bank #(
    parameter int OUT_BITWIDTH       = 16,
    parameter int PSUM_ADDR_BITWIDTH = 2,
    parameter bit CLEAR_ON_DRAIN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mac_out_en,
    input  logic [PSUM_ADDR_BITWIDTH-1:0] mac_write_addr,
    input  logic [OUT_BITWIDTH-1:0]       mac_out,
    input  logic [PSUM_ADDR_BITWIDTH-1:0] psum_read_addr,
    output logic [OUT_BITWIDTH-1:0]       sum_out,
    input  logic                          clear,
    input  logic                          drain_start,
    output logic                          busy,
    output logic                          wr_drop,
    rf_psum_bank_if.master                drain
);

    localparam int DEPTH = 1 << PSUM_ADDR_BITWIDTH;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } state_t;

    state_t                          state;
    logic [PSUM_ADDR_BITWIDTH-1:0]   idx;
    logic [OUT_BITWIDTH-1:0]         mem [DEPTH];

    logic idle_write;
    logic idx_last;

    assign idle_write = (state == ST_IDLE) && mac_out_en && !clear;
    assign idx_last   = &idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            wr_drop <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr_drop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // clear takes priority over a same-cycle MAC write
                    if (clear) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            mem[i] <= '0;
                        end
                        wr_drop <= mac_out_en;
                    end else if (mac_out_en) begin
                        mem[mac_write_addr] <= mac_out;
                    end
                    if (drain_start) begin
                        state <= ST_DRAIN;
                        idx   <= '0;
                    end
                end
                ST_DRAIN: begin
                    wr_drop <= mac_out_en;
                    if (drain.drain_ready) begin
                        if (CLEAR_ON_DRAIN) begin
                            mem[idx] <= '0;
                        end
                        idx <= idx + PSUM_ADDR_BITWIDTH'(1);
                        if (idx_last) begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign busy              = (state == ST_DRAIN);
    assign drain.drain_valid = (state == ST_DRAIN);
    assign drain.drain_addr  = idx;
    assign drain.drain_data  = mem[idx];
    assign drain.drain_last  = (state == ST_DRAIN) && idx_last;

    // Write-first bypass lets the MAC see its own result within the write cycle
    assign sum_out = (idle_write && (mac_write_addr == psum_read_addr)) ? mac_out
                                                                        : mem[psum_read_addr];

endmodule

// File: tb/tb_rf_psum_bank.sv
// Bench for rf_psum_bank: reference bank model plus a drain scoreboard/monitor.
module tb_rf_psum_bank;

    localparam int W     = 16;
    localparam int N     = 2;
    localparam int DEPTH = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mac_out_en = 1'b0;
    logic [N-1:0] mac_write_addr = '0;
    logic [W-1:0] mac_out = '0;
    logic [N-1:0] psum_read_addr = '0;
    logic [W-1:0] sum_out;
    logic         clear = 1'b0;
    logic         drain_start = 1'b0;
    logic         busy;
    logic         wr_drop;

    always #5 clk = ~clk;

    rf_psum_bank_if #(.OUT_BITWIDTH(W), .PSUM_ADDR_BITWIDTH(N)) drain_if ();

    rf_psum_bank #(
        .OUT_BITWIDTH      (W),
        .PSUM_ADDR_BITWIDTH(N),
        .CLEAR_ON_DRAIN    (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mac_out_en    (mac_out_en),
        .mac_write_addr(mac_write_addr),
        .mac_out       (mac_out),
        .psum_read_addr(psum_read_addr),
        .sum_out       (sum_out),
        .clear         (clear),
        .drain_start   (drain_start),
        .busy          (busy),
        .wr_drop       (wr_drop),
        .drain         (drain_if)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [N-1:0] addr;
        logic         last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    beat_t mon_beat;

    logic [W-1:0] ref_mem [DEPTH];
    bit           ref_busy = 1'b0;
    int           ref_sent = 0;
    bit           ref_drop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_busy = 1'b0;
        ref_sent = 0;
        ref_drop = 1'b0;
        exp_q.delete();
    endtask

    // Applies the bank's rules for one clock edge to the reference state
    task automatic model_edge();
        bit next_drop;
        next_drop = 1'b0;
        if (!ref_busy) begin
            if (clear) begin
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                next_drop = mac_out_en;
            end else if (mac_out_en) begin
                ref_mem[mac_write_addr] = mac_out;
            end
            if (drain_start) begin
                ref_busy = 1'b1;
                ref_sent = 0;
                for (int i = 0; i < DEPTH; i++)
                    exp_q.push_back(beat_t'{ref_mem[i], N'(i), (i == DEPTH - 1)});
            end
        end else begin
            next_drop = mac_out_en;
            if (drain_if.drain_ready) begin
                ref_mem[ref_sent] = '0;
                ref_sent++;
                if (ref_sent == DEPTH) ref_busy = 1'b0;
            end
        end
        ref_drop = next_drop;
    endtask

    task automatic step();
        logic [W-1:0] exp_sum;
        @(negedge clk);
        if (!ref_busy && mac_out_en && !clear && (mac_write_addr == psum_read_addr))
            exp_sum = mac_out;
        else
            exp_sum = ref_mem[psum_read_addr];
        check("sum_out", sum_out, exp_sum);
        check("busy", busy, ref_busy);
        check("drain_valid", drain_if.drain_valid, ref_busy);
        check("wr_drop", wr_drop, ref_drop);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic preload(input logic [W-1:0] v0, input logic [W-1:0] v1,
                           input logic [W-1:0] v2, input logic [W-1:0] v3);
        logic [W-1:0] vals [DEPTH];
        vals = '{v0, v1, v2, v3};
        for (int i = 0; i < DEPTH; i++) begin
            mac_out_en     = 1'b1;
            mac_write_addr = N'(i);
            mac_out        = vals[i];
            step();
        end
        mac_out_en = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready follows 1,0,0,1
    task automatic run_drain(input int mode);
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        for (int k = 0; k < 40 && ref_busy; k++) begin
            drain_if.drain_ready = (mode == 0) ? 1'b1 : pat[k % 4];
            step();
        end
        check("drain_done", ref_busy, 1'b0);
        check("drain_q_empty", exp_q.size(), 0);
        drain_if.drain_ready = 1'b0;
    endtask

    logic         stall_prev = 1'b0;
    logic [W-1:0] stall_data;
    logic [N-1:0] stall_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else if (drain_if.drain_valid) begin
            if (stall_prev) begin
                check("hold_data", drain_if.drain_data, stall_data);
                check("hold_addr", drain_if.drain_addr, stall_addr);
            end
            if (drain_if.drain_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain_extra: got addr %0h with no word expected", drain_if.drain_addr);
                end else begin
                    mon_beat = exp_q.pop_front();
                    check("drain_data", drain_if.drain_data, mon_beat.data);
                    check("drain_addr", drain_if.drain_addr, mon_beat.addr);
                    check("drain_last", drain_if.drain_last, mon_beat.last);
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_data = drain_if.drain_data;
                stall_addr = drain_if.drain_addr;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drain_if.drain_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_drain_valid", drain_if.drain_valid, 1'b0);
        check("rst_drain_last", drain_if.drain_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_drop", wr_drop, 1'b0);
        check("rst_drain_addr", drain_if.drain_addr, '0);
        check("rst_drain_data", drain_if.drain_data, '0);
        for (int i = 0; i < DEPTH; i++) begin
            psum_read_addr = N'(i);
            #1;
            check("rst_sum_out", sum_out, '0);
        end
        rst_n = 1'b1;

        // single write with bypass, then readback
        mac_out_en = 1'b1; mac_write_addr = 2; mac_out = 16'h0011; psum_read_addr = 2;
        step();
        mac_out_en = 1'b0;
        step();
        check("write_readback", sum_out, 16'h0011);

        // accumulation a=3, w=4 into addr 1
        psum_read_addr = 1;
        for (int k = 1; k <= 3; k++) begin
            mac_out_en = 1'b1; mac_write_addr = 1; mac_out = W'(3 * 4 * k);
            step();
        end
        mac_out_en = 1'b0;
        step();
        check("accum_36", sum_out, 16'd36);

        preload(16'd5, 16'd6, 16'd7, 16'd8);
        run_drain(0);
        for (int i = 0; i < DEPTH; i++) begin
            psum_read_addr = N'(i);
            step();
        end

        preload(16'd5, 16'd6, 16'd7, 16'd8);
        run_drain(1);

        // write dropped during a drain stall; entry 3 must still drain its preload
        preload(16'h0101, 16'h0202, 16'h0303, 16'h0404);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        drain_if.drain_ready = 1'b0;
        mac_out_en = 1'b1; mac_write_addr = 3; mac_out = 16'hBEEF;
        step();
        mac_out_en = 1'b0;
        step();
        drain_if.drain_ready = 1'b1;
        for (int k = 0; k < 20 && ref_busy; k++) step();
        check("drop_drain_done", exp_q.size(), 0);
        drain_if.drain_ready = 1'b0;

        // clear beats a same-cycle write
        mac_out_en = 1'b1; mac_write_addr = 1; mac_out = 16'h0077; psum_read_addr = 1;
        step();
        clear = 1'b1; mac_out = 16'h0099;
        step();
        clear = 1'b0; mac_out_en = 1'b0;
        step();
        check("clear_wins", sum_out, '0);

        for (int k = 0; k < 400; k++) begin
            mac_out_en           = 1'($urandom_range(0, 1));
            mac_write_addr       = N'($urandom_range(0, DEPTH - 1));
            mac_out              = W'($urandom);
            psum_read_addr       = N'($urandom_range(0, DEPTH - 1));
            clear                = ($urandom_range(0, 19) == 0);
            drain_start          = ($urandom_range(0, 15) == 0);
            drain_if.drain_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        mac_out_en = 1'b0; clear = 1'b0; drain_start = 1'b0;
        drain_if.drain_ready = 1'b1;
        for (int k = 0; k < 20 && ref_busy; k++) step();
        check("rand_drain_done", exp_q.size(), 0);
        drain_if.drain_ready = 1'b0;

        // reset after the second drain transfer
        preload(16'd1, 16'd2, 16'd3, 16'd4);
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        drain_if.drain_ready = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_drain_valid", drain_if.drain_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_drain_addr", drain_if.drain_addr, '0);
        for (int i = 0; i < DEPTH; i++) begin
            psum_read_addr = N'(i);
            #1;
            check("midrst_entry", sum_out, '0);
        end
        drain_if.drain_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_drain(0);

        check("final_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_psum_bank.md
# rf_psum_bank

Partial-sum register file that sits on the receiving end of a MAC unit's output port. It accepts accumulated results tagged with a write address, feeds the stored partial sum back to the MAC's `sum_in` for the next accumulation, and drains its full contents to the global buffer through a valid/ready handshake when a tile completes. It is one instance per PE, alongside the MAC.

## Interface
- `OUT_BITWIDTH`, 16, width of every partial sum (matches MAC output width)
- `PSUM_ADDR_BITWIDTH`, 2, address width; depth = 2^PSUM_ADDR_BITWIDTH entries
- `CLEAR_ON_DRAIN`, 1, when 1, each entry is zeroed in the cycle it is drained
- `clk`  in  1  single clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `mac_out_en`  in  1  write strobe from MAC (its `out_en`)
- `mac_write_addr`  in  PSUM_ADDR_BITWIDTH  write address from MAC
- `mac_out`  in  OUT_BITWIDTH  accumulated value from MAC
- `psum_read_addr`  in  PSUM_ADDR_BITWIDTH  entry to present on `sum_out`
- `sum_out`  out  OUT_BITWIDTH  stored partial sum; drives the MAC's `sum_in`
- `clear`  in  1  synchronous zeroing of all entries (IDLE only)
- `drain_start`  in  1  request to stream all entries out
- `drain_valid`  out  1  drain word valid
- `drain_ready`  in  1  downstream accepts the drain word
- `drain_data`  out  OUT_BITWIDTH  drained entry value
- `drain_addr`  out  PSUM_ADDR_BITWIDTH  index of the drained entry
- `drain_last`  out  1  high with the final entry (index 2^PSUM_ADDR_BITWIDTH-1)
- `busy`  out  1  high while in DRAIN
- `wr_drop`  out  1  one-cycle pulse: a MAC write was discarded

## Operation
- Storage: 2^PSUM_ADDR_BITWIDTH registers of OUT_BITWIDTH bits. Values are stored unmodified; no arithmetic is done in this block.
- FSM states: IDLE and DRAIN.
- IDLE:
  - `mac_out_en`=1 writes `mac_out` into `mem[mac_write_addr]` at posedge.
  - `clear`=1 zeroes all entries. If `clear` and `mac_out_en` are both high, `clear` wins: the write is discarded and `wr_drop` pulses.
  - `drain_start`=1 moves to DRAIN with index 0. A write in the same cycle is still performed, so the drain sees it.
- DRAIN:
  - `drain_valid`=1, `drain_addr`=index, `drain_data`=`mem[index]` (combinational from storage).
  - On `drain_valid && drain_ready` at posedge: if CLEAR_ON_DRAIN, `mem[index]` is set to 0; then the index increments.
  - A transfer at index 2^N-1 (`drain_last`=1) returns the FSM to IDLE.
  - `mac_out_en` in DRAIN is discarded, and `wr_drop` pulses the next cycle.
  - `clear` and `drain_start` are ignored in DRAIN.
- Read port: `sum_out` = `mem[psum_read_addr]`, combinational, with write-first bypass. When in IDLE, `mac_out_en`=1, `clear`=0 and `mac_write_addr`==`psum_read_addr`, `sum_out`=`mac_out`.
- Index wraps naturally at 2^N; the FSM exits on the wrap transfer, so there is no second pass.

## Timing
- Reset (async, `rst_n`=0):
  - all entries 0, FSM IDLE, index 0.
  - `drain_valid`, `drain_last`, `busy` and `wr_drop` are 0; `drain_addr`=0 and `drain_data`=`mem[0]`=0.
  - `sum_out`=0.
- Reset asserted mid-drain aborts immediately. Partially drained state is lost; all entries read 0.
- Write latency: a value written at posedge k is visible on `sum_out` after posedge k. It is visible before the edge through the bypass. This lets the MAC (negedge-driven) read back its own result on the next negedge.
- Drain start: `drain_start` sampled at posedge k; `drain_valid`=1 from after edge k.
- Drain throughput: one entry per cycle with `drain_ready` held high. The full drain takes 2^N cycles; `busy` falls after the edge of the last transfer.
- Backpressure: with `drain_ready`=0, `drain_valid`, `drain_addr` and `drain_data` hold stable.
- `wr_drop` is registered: high for exactly one cycle, the cycle after the discarded write edge.

## Test plan
- Reset, then write 0x0011 to addr 2 at edge 1 -> `sum_out` with `psum_read_addr`=2 is 0x0011 after edge 1, and 0x0011 during the write cycle via bypass.
- Accumulation loop with the MAC: a=3, w=4, addr=1, three enables -> `mem[1]` = 12, 24, 36 on successive cycles.
- Preload 5,6,7,8 into addr 0..3, pulse `drain_start`, `drain_ready`=1 -> data 5,6,7,8 with addr 0..3 on four consecutive cycles, `drain_last` on 8. Then `busy`=0 and all entries 0 (CLEAR_ON_DRAIN=1).
- Same drain with `drain_ready` toggling 1,0,0,1,… -> each word held stable while ready is 0, no word skipped or duplicated, exactly 4 transfers.
- `mac_out_en` at addr 0 during DRAIN, and `clear`+`mac_out_en` in IDLE -> both writes discarded, `wr_drop` one-cycle pulse each time, entry unchanged or 0 respectively.
- `rst_n` low after the second drain transfer -> `drain_valid`=0 and `busy`=0 immediately, all entries 0, and a new `drain_start` restarts at addr 0.
